// File: rtl/modport_core_pkg.sv
// Shared opcode constants, ALU operation and FSM state types for modport_core.
package modport_core_pkg;

    localparam logic [6:0] OPC_OP    = 7'h33;
    localparam logic [6:0] OPC_OPIMM = 7'h13;
    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_IWAIT, S_EXEC, S_DREQ, S_DWAIT
    } state_e;

    // alt selects SUB/SRA; callers gate it so ADDI never becomes a subtract
    function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/modport_core_alu.sv
// Combinational 32-bit integer ALU; shifts use the low five bits of b.
module modport_core_alu
    import modport_core_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [4:0]         shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt;
            ALU_SLT:   y = {31'b0, a_s < b_s};
            ALU_SLTU:  y = {31'b0, a < b};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = a_s >>> shamt;
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/modport_core.sv
// Multi-cycle RV32I-subset core: fetch/execute FSM, register file and data port.
module modport_core
    import modport_core_pkg::*;
#(
    parameter int INSTR_RDATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clock_en_i,
    input  logic                         fetch_enable_i,
    input  logic [31:0]                  boot_addr_i,
    input  logic [3:0]                   core_id_i,
    input  logic [5:0]                   cluster_id_i,
    output logic                         instr_req_o,
    output logic [31:0]                  instr_addr_o,
    input  logic                         instr_gnt_i,
    input  logic                         instr_rvalid_i,
    input  logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_i,
    output logic                         data_req_o,
    output logic                         data_we_o,
    output logic [3:0]                   data_be_o,
    output logic [31:0]                  data_addr_o,
    output logic [31:0]                  data_wdata_o,
    input  logic                         data_gnt_i,
    input  logic                         data_rvalid_i,
    input  logic [31:0]                  data_rdata_i,
    output logic                         core_rbusy_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, instr_q, daddr_q, dwdata_q;
    logic [31:0] regs_q [32];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_u, alu_b, alu_y, mem_addr;
    alu_op_e     alu_op;
    logic        alu_wr, is_load, is_store;
    logic        unused_ok;

    assign unused_ok = ^{core_id_i, cluster_id_i};

    assign opcode  = instr_q[6:0];
    assign rd      = instr_q[11:7];
    assign funct3  = instr_q[14:12];
    assign rs1     = instr_q[19:15];
    assign rs2     = instr_q[24:20];
    assign funct7  = instr_q[31:25];
    assign imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_u   = {instr_q[31:12], 12'b0};
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);

    // Decode; anything not recognised leaves alu_wr/is_load/is_store low and runs as a NOP
    always_comb begin
        alu_op   = ALU_ADD;
        alu_b    = rs2_val;
        alu_wr   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op = alu_op_from_funct(funct3, funct7[5]);
                alu_wr = (funct7 == 7'h00) ||
                         (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
            end
            OPC_OPIMM: begin
                alu_b  = imm_i;
                alu_op = alu_op_from_funct(funct3, funct3 == 3'd5 && funct7[5]);
                if (funct3 == 3'd1)      alu_wr = (funct7 == 7'h00);
                else if (funct3 == 3'd5) alu_wr = (funct7 == 7'h00) || (funct7 == 7'h20);
                else                     alu_wr = 1'b1;
            end
            OPC_LUI: begin
                alu_op = ALU_PASSB;
                alu_b  = imm_u;
                alu_wr = 1'b1;
            end
            OPC_LOAD:  is_load  = (funct3 == 3'd2);
            OPC_STORE: is_store = (funct3 == 3'd2);
            default: ;
        endcase
    end

    modport_core_alu u_alu (
        .op (alu_op),
        .a  (rs1_val),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_comb begin
        state_d      = state_q;
        instr_req_o  = (state_q == S_FETCH);
        data_req_o   = (state_q == S_DREQ);
        data_we_o    = (state_q == S_DREQ) && is_store;
        data_be_o    = (state_q == S_DREQ) ? 4'hF : 4'h0;
        core_rbusy_o = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (fetch_enable_i) state_d = S_FETCH;
            // an issued request that is granted is honoured even if fetch is being disabled
            S_FETCH: begin
                if (instr_gnt_i)          state_d = S_IWAIT;
                else if (!fetch_enable_i) state_d = S_IDLE;
            end
            S_IWAIT: if (instr_rvalid_i) state_d = S_EXEC;
            S_EXEC:  state_d = (is_load || is_store) ? S_DREQ : S_FETCH;
            S_DREQ:  if (data_gnt_i) state_d = S_DWAIT;
            S_DWAIT: if (data_rvalid_i) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_addr_o = pc_q;
    assign data_addr_o  = daddr_q;
    assign data_wdata_o = dwdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            pc_q     <= boot_addr_i & ~32'd3;
            instr_q  <= '0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (clock_en_i) begin
            state_q <= state_d;
            case (state_q)
                S_IWAIT: if (instr_rvalid_i) instr_q <= 32'(instr_rdata_i);
                S_EXEC: begin
                    if (is_load || is_store) begin
                        daddr_q <= mem_addr & ~32'd3;
                        if (is_store) dwdata_q <= rs2_val;
                    end else begin
                        pc_q <= pc_q + 32'd4;
                        if (alu_wr && rd != 5'd0) regs_q[rd] <= alu_y;
                    end
                end
                S_DWAIT: begin
                    if (data_rvalid_i) begin
                        pc_q <= pc_q + 32'd4;
                        if (is_load && rd != 5'd0) regs_q[rd] <= data_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modport_core.sv
// Bench for modport_core: directed program steps plus random instructions against an ISA-level model.
module tb_modport_core;

    logic        clk_i = 1'b0;
    logic        rst_ni, clock_en_i, fetch_enable_i;
    logic [31:0] boot_addr_i;
    logic [3:0]  core_id_i;
    logic [5:0]  cluster_id_i;
    logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
    logic [31:0] instr_addr_o, instr_rdata_i;
    logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i, core_rbusy_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

    int total = 0;
    int bad   = 0;

    bit [31:0]   m_regs [32];
    bit [31:0]   m_pc, m_last_wd;
    logic [31:0] obs_addr, obs_wdata;
    logic        obs_we;
    logic [3:0]  obs_be;

    always #5 clk_i = ~clk_i;

    modport_core #(.INSTR_RDATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clock_en_i(clock_en_i), .fetch_enable_i(fetch_enable_i),
        .boot_addr_i(boot_addr_i), .core_id_i(core_id_i), .cluster_id_i(cluster_id_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .core_rbusy_o(core_rbusy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset(input bit [31:0] boot);
        m_pc = {boot[31:2], 2'b00};
        m_last_wd = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // Architectural effect of one instruction, straight from the ISA rules
    task automatic m_exec(input bit [31:0] ins, input bit [31:0] ldata,
                          output bit is_mem, output bit is_st,
                          output bit [31:0] ea, output bit [31:0] ewd);
        bit [31:0] a, b, immi, imms, res, sum;
        bit [6:0]  f7;
        bit [2:0]  f3;
        bit [4:0]  sh;
        bit        has;
        a    = m_regs[ins[19:15]];
        b    = m_regs[ins[24:20]];
        f3   = ins[14:12];
        f7   = ins[31:25];
        sh   = ins[24:20];
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        has = 0; res = '0; is_mem = 0; is_st = 0; ea = '0; ewd = m_last_wd;
        case (ins[6:0])
            7'h33: begin
                has = 1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: res = a + b;
                        3'd1: res = a << b[4:0];
                        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: res = (a < b) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ b;
                        3'd5: res = a >> b[4:0];
                        3'd6: res = a | b;
                        default: res = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
                else if (f7 == 7'h20 && f3 == 3'd5) res = $signed(a) >>> b[4:0];
                else has = 0;
            end
            7'h13: begin
                has = 1;
                case (f3)
                    3'd0: res = a + immi;
                    3'd2: res = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < immi) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ immi;
                    3'd6: res = a | immi;
                    3'd7: res = a & immi;
                    3'd1: if (f7 == 7'h00) res = a << sh; else has = 0;
                    default: begin
                        if (f7 == 7'h00) res = a >> sh;
                        else if (f7 == 7'h20) res = $signed(a) >>> sh;
                        else has = 0;
                    end
                endcase
            end
            7'h37: begin has = 1; res = {ins[31:12], 12'b0}; end
            7'h03: if (f3 == 3'd2) begin
                is_mem = 1; sum = a + immi; ea = {sum[31:2], 2'b00}; has = 1; res = ldata;
            end
            7'h23: if (f3 == 3'd2) begin
                is_mem = 1; is_st = 1; sum = a + imms; ea = {sum[31:2], 2'b00}; ewd = b;
            end
            default: ;
        endcase
        if (has && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
        m_last_wd = ewd;
        m_pc = m_pc + 32'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        f7  = 7'h00;
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
                if ($urandom_range(0, 7) == 0) f7 = 7'h01;
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            3, 4, 5: begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return {imm, rs1, f3, rd, 7'h13};
            end
            6: return {20'($urandom), rd, 7'h37};
            7: return {imm, rs1, 3'b010, rd, 7'h03};
            8: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            default: return {25'($urandom), 7'h6F};
        endcase
    endfunction

    // One instruction through the bus handshakes; dly stretches grant/valid, frz gates clock_en in DREQ
    task automatic step(input logic [31:0] ins, input logic [31:0] ldata,
                        input int dly, input int frz, input bit abort);
        int        n;
        bit        mem, st;
        bit [31:0] ea, ewd;
        logic [31:0] a0;
        n = 0;
        while (instr_req_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        chk("fetch_req", {31'b0, instr_req_o}, 32'd1);
        if (instr_req_o !== 1'b1) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "no instruction request within 20 cycles");
        end
        chk("fetch_addr", instr_addr_o, m_pc);
        a0 = instr_addr_o;
        for (int i = 0; i < dly; i++) begin
            instr_gnt_i = 0; instr_rvalid_i = 1'($urandom); instr_rdata_i = $urandom;
            @(negedge clk_i);
            chk("fetch_hold_req", {31'b0, instr_req_o}, 32'd1);
            chk("fetch_hold_addr", instr_addr_o, a0);
        end
        instr_gnt_i = 1; instr_rvalid_i = 1'($urandom); instr_rdata_i = $urandom;
        @(negedge clk_i);
        instr_gnt_i = 0; instr_rvalid_i = 0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk_i);
            chk("iwait_req", {31'b0, instr_req_o}, 32'd0);
        end
        instr_rvalid_i = 1; instr_rdata_i = ins;
        @(negedge clk_i);
        instr_rvalid_i = 0; instr_rdata_i = $urandom;
        m_exec(ins, ldata, mem, st, ea, ewd);
        if (mem) begin
            @(negedge clk_i);
            chk("dreq_req", {31'b0, data_req_o}, 32'd1);
            chk("dreq_we", {31'b0, data_we_o}, {31'b0, st});
            chk("dreq_be", {28'b0, data_be_o}, 32'hF);
            chk("dreq_addr", data_addr_o, ea);
            chk("dreq_wdata", data_wdata_o, ewd);
            chk("dreq_no_fetch", {31'b0, instr_req_o}, 32'd0);
            obs_addr = data_addr_o; obs_wdata = data_wdata_o; obs_we = data_we_o; obs_be = data_be_o;
            if (abort) begin
                rst_ni = 0;
                #1;
                chk("abort_dreq", {31'b0, data_req_o}, 32'd0);
                chk("abort_busy", {31'b0, core_rbusy_o}, 32'd0);
                chk("abort_addr", data_addr_o, 32'd0);
                chk("abort_wdata", data_wdata_o, 32'd0);
                chk("abort_be", {28'b0, data_be_o}, 32'd0);
            end else begin
                for (int i = 0; i < dly; i++) begin
                    data_gnt_i = 0; data_rvalid_i = 1'($urandom);
                    @(negedge clk_i);
                    chk("dhold_req", {31'b0, data_req_o}, 32'd1);
                    chk("dhold_addr", data_addr_o, ea);
                    chk("dhold_wdata", data_wdata_o, ewd);
                    chk("dhold_we", {31'b0, data_we_o}, {31'b0, st});
                    chk("dhold_no_fetch", {31'b0, instr_req_o}, 32'd0);
                end
                if (frz > 0) begin
                    clock_en_i = 0; data_gnt_i = 1; data_rvalid_i = 1;
                    for (int i = 0; i < frz; i++) begin
                        @(negedge clk_i);
                        chk("freeze_req", {31'b0, data_req_o}, 32'd1);
                        chk("freeze_pc", instr_addr_o, a0);
                    end
                    clock_en_i = 1;
                end
                data_gnt_i = 1; data_rvalid_i = 0;
                @(negedge clk_i);
                data_gnt_i = 0;
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk_i);
                    chk("dwait_req", {31'b0, data_req_o}, 32'd0);
                    chk("dwait_no_fetch", {31'b0, instr_req_o}, 32'd0);
                end
                data_rvalid_i = 1; data_rdata_i = ldata;
                @(negedge clk_i);
                data_rvalid_i = 0; data_rdata_i = $urandom;
            end
        end
    endtask

    initial begin
        rst_ni = 0; clock_en_i = 1; fetch_enable_i = 0; boot_addr_i = 32'h0000000A;
        core_id_i = 4'h3; cluster_id_i = 6'h15;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
        m_reset(32'h0000000A);
        repeat (2) @(negedge clk_i);
        chk("rst_ireq", {31'b0, instr_req_o}, 32'd0);
        chk("rst_dreq", {31'b0, data_req_o}, 32'd0);
        chk("rst_we", {31'b0, data_we_o}, 32'd0);
        chk("rst_be", {28'b0, data_be_o}, 32'd0);
        chk("rst_daddr", data_addr_o, 32'd0);
        chk("rst_wdata", data_wdata_o, 32'd0);
        chk("rst_busy", {31'b0, core_rbusy_o}, 32'd0);
        rst_ni = 1;
        repeat (3) @(negedge clk_i);
        chk("idle_ireq", {31'b0, instr_req_o}, 32'd0);
        chk("idle_busy", {31'b0, core_rbusy_o}, 32'd0);
        fetch_enable_i = 1;
        @(negedge clk_i);
        chk("enable_ireq", {31'b0, instr_req_o}, 32'd1);
        chk("boot_addr", instr_addr_o, 32'h00000008);
        chk("enable_busy", {31'b0, core_rbusy_o}, 32'd1);

        step(32'h00500113, 0, 0, 0, 0);
        step(32'h00700193, 0, 0, 0, 0);
        step(32'h002180B3, 0, 1, 0, 0);
        step(32'h00102023, 0, 5, 0, 0);
        chk("sum_we", {31'b0, obs_we}, 32'd1);
        chk("sum_addr", obs_addr, 32'd0);
        chk("sum_wdata", obs_wdata, 32'd12);
        chk("sum_be", {28'b0, obs_be}, 32'hF);

        step(32'h00402283, 32'hDEADBEEF, 1, 0, 0);
        chk("lw_addr", obs_addr, 32'd4);
        chk("lw_we", {31'b0, obs_we}, 32'd0);
        step(32'h00502423, 0, 0, 3, 0);
        chk("sw_addr", obs_addr, 32'd8);
        chk("sw_wdata", obs_wdata, 32'hDEADBEEF);

        step(32'h00900013, 0, 0, 0, 0);
        step(32'h00002023, 0, 0, 0, 0);
        chk("x0_wdata", obs_wdata, 32'd0);

        for (int k = 0; k < 60; k++)
            step(rand_instr(), $urandom, $urandom_range(0, 2), 0, 0);
        for (int r = 1; r < 8; r++)
            step({7'd0, 5'(r), 5'd0, 3'b010, 5'd0, 7'h23}, 0, 0, 0, 0);

        step({7'd0, 5'd3, 5'd0, 3'b010, 5'd16, 7'h23}, 0, 1, 0, 1);
        boot_addr_i = 32'h00000107;
        m_reset(32'h00000107);
        @(negedge clk_i);
        rst_ni = 1;
        step({7'd0, 5'd3, 5'd0, 3'b010, 5'd0, 7'h23}, 0, 0, 0, 0);
        chk("post_abort_wdata", obs_wdata, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modport_core.md
MODPORT_CORE -- requirements
Module: modport_core

Interface
REQ-001 Parameter INSTR_RDATA_WIDTH, default 32, width of instr_rdata_i; only 32 is supported.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock; rst_ni input 1, asynchronous active-low reset.
REQ-003 clock_en_i input 1: when low, all state and register updates freeze and outputs hold.
REQ-004 fetch_enable_i input 1: permits new instruction fetches.
REQ-005 boot_addr_i input 32: start address, sampled while rst_ni is low.
REQ-006 core_id_i input 4 and cluster_id_i input 6: identity inputs, functionally unused.
REQ-007 instr_req_o output 1, instr_addr_o output 32, instr_gnt_i input 1, instr_rvalid_i input 1, instr_rdata_i input 32: instruction fetch request/grant/valid channel.
REQ-008 data_req_o output 1, data_we_o output 1, data_be_o output 4, data_addr_o output 32, data_wdata_o output 32, data_gnt_i input 1, data_rvalid_i input 1, data_rdata_i input 32: data memory channel.
REQ-009 core_rbusy_o output 1: high whenever the FSM is not in IDLE.

Function
REQ-010 FSM states: IDLE, FETCH, IWAIT, EXEC, DREQ, DWAIT.
REQ-011 IDLE -> FETCH when fetch_enable_i=1; FETCH with fetch_enable_i=0 -> IDLE.
REQ-012 FETCH drives instr_req_o=1 and instr_addr_o=PC; on instr_gnt_i=1 -> IWAIT; without a grant, request and address stay stable.
REQ-013 IWAIT, from the cycle after the grant, latches instr_rdata_i on instr_rvalid_i=1 -> EXEC.
REQ-014 EXEC takes one cycle: decodes and executes, writes rd, sets PC=PC+4, then -> FETCH; LW/SW go -> DREQ instead.
REQ-015 Supported opcodes: OP (0x33: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND), OP-IMM (0x13: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), LUI (0x37), LW (0x03, funct3=2), SW (0x23, funct3=2).
REQ-016 Any other encoding executes as a NOP (PC+4, no register write).
REQ-017 Arithmetic is 32-bit modulo 2^32; immediates are sign-extended; shift amount is bits [4:0].
REQ-018 Register file: 32x32 with x0 hard-wired to 0; writes to x0 are discarded.
REQ-019 DREQ drives data_req_o=1, data_addr_o={(rs1+imm)[31:2],2'b00}, data_be_o=4'b1111, data_we_o=1 for SW else 0, and data_wdata_o=rs2 value for SW; on data_gnt_i=1 -> DWAIT.
REQ-020 DREQ outputs stay stable while data_gnt_i=0, for any number of cycles.
REQ-021 DWAIT, on data_rvalid_i=1: LW writes data_rdata_i to rd; then PC+4 -> FETCH.
REQ-022 Fetch is never issued while a data transaction is outstanding.
REQ-023 Minimum latency with permanent grant/valid: ALU instruction 3 cycles; LW/SW 5 cycles.
REQ-024 data_wdata_o holds its last value outside DREQ; instr_addr_o always reflects PC.
REQ-025 An rvalid arriving in any state other than IWAIT or DWAIT is ignored.

Reset
REQ-026 With rst_ni low: state=IDLE, PC={boot_addr_i[31:2],2'b00}, all registers 0, every request/we output 0, data_be_o=0, data_addr_o=0, data_wdata_o=0.
REQ-027 Reset asserted mid-transaction aborts it immediately, with no register write.

Structure
REQ-028 A shared package SHALL hold the opcode constants, the ALU-operation enum and the FSM state enum.
REQ-029 A single sub-module modport_core_alu SHALL implement the combinational ALU; the register file and FSM SHALL be in the top.

Verification
REQ-030 Reset with boot_addr_i=0x0000000A, fetch_enable_i=1 -> first request has instr_addr_o=0x00000008.
REQ-031 Sequence 0x00500113, 0x00700193, 0x002180B3, 0x00102023 -> data_we_o=1, data_addr_o=0, data_wdata_o=12, data_be_o=F.
REQ-032 During an SW, hold data_gnt_i=0 for 5 cycles -> data_req_o, addr and wdata are stable and instr_req_o=0 for all 5.
REQ-033 0x00402283 with data_rdata_i=0xDEADBEEF, then 0x00502423 -> LW address 4; SW data_addr_o=8, data_wdata_o=0xDEADBEEF.
REQ-034 0x00900013, then 0x00002023 -> data_wdata_o=0.
REQ-035 fetch_enable_i=0 after reset -> instr_req_o stays 0 and core_rbusy_o=0; raising it gives a request the next cycle.
